// File: rtl/cpu_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package cpu_pkg;

  localparam int unsigned DATA_W               = 32;
  localparam int unsigned WORD_BYTES           = 4;
  localparam int unsigned DMEM_LATENCY_DEFAULT = 3;
  localparam int unsigned CNT_W                = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dmem_state_t;

  // Request payload captured in IDLE and held through ACCESS.
  typedef struct packed {
    logic              write;
    logic [DATA_W-1:0] wdata;
  } dmem_cap_t;

endpackage

// File: rtl/dmem_responder_if.sv
// EX_MEM -> data-memory request bus with its completion/stall return path.
interface dmem_responder_if;

  logic                        MemRead_i;
  logic                        MemWrite_i;
  logic [cpu_pkg::DATA_W-1:0]  Addr_i;
  logic [cpu_pkg::DATA_W-1:0]  WriteData_i;
  logic [cpu_pkg::DATA_W-1:0]  ReadData_o;
  logic                        ack_o;
  logic                        err_o;
  logic                        stall_o;

  modport master (
    output MemRead_i, MemWrite_i, Addr_i, WriteData_i,
    input  ReadData_o, ack_o, err_o, stall_o
  );

  modport slave (
    input  MemRead_i, MemWrite_i, Addr_i, WriteData_i,
    output ReadData_o, ack_o, err_o, stall_o
  );

endinterface

// File: rtl/dmem_array.sv
// Synchronous single-port DEPTH x 32 data array; read data is registered.
module dmem_array
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port and registered read port share one index.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
    rdata_o <= mem_q[idx_i];
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: stalls the pipeline for LATENCY cycles
// per access and completes with a one-cycle ack carrying data or an error.
module dmem_responder
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = DMEM_LATENCY_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  dmem_responder_if.slave  bus
);

  dmem_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  dmem_cap_t         cap_q, cap_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;

  logic              req_c;
  logic              bad_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] addr_idx_c;
  logic [ADDR_W-1:0] mem_idx_c;
  logic [DATA_W-1:0] mem_rdata;

  // Request decode: misaligned, out-of-range or read+write together is an error.
  always_comb begin
    req_c      = bus.MemRead_i | bus.MemWrite_i;
    addr_idx_c = bus.Addr_i[ADDR_W+1:2];
    bad_c      = ((bus.Addr_i & DATA_W'(WORD_BYTES - 1)) != '0)
               | ((bus.Addr_i >> (ADDR_W + 2)) != '0)
               | (bus.MemRead_i & bus.MemWrite_i);
  end

  // Address the array from the bus in IDLE so read data is ready by the last ACCESS cycle.
  always_comb begin
    mem_idx_c = (state_q == IDLE) ? addr_idx_c : idx_q;
  end

  // Next-state, counter, capture and output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    cap_d    = cap_q;
    rdata_d  = rdata_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    mem_we_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_c) begin
          cap_d.write = bus.MemWrite_i;
          cap_d.wdata = bus.WriteData_i;
          idx_d       = addr_idx_c;
          if (bad_c) begin
            state_d = RESP;
            ack_d   = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = ACCESS;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = RESP;
          ack_d   = 1'b1;
          if (cap_q.write) begin
            mem_we_c = 1'b1;
          end else begin
            rdata_d = mem_rdata;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state and registered outputs; reset aborts any access in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Captured request payload; only meaningful while an access is in flight.
  always_ff @(posedge clk_i) begin
    idx_q <= idx_d;
    cap_q <= cap_d;
  end

  dmem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (mem_we_c & rst_i),
    .idx_i   (mem_idx_c),
    .wdata_i (cap_q.wdata),
    .rdata_o (mem_rdata)
  );

  assign bus.ReadData_o = rdata_q;
  assign bus.ack_o      = ack_q;
  assign bus.err_o      = err_q;
  assign bus.stall_o    = ((state_q == IDLE) & req_c) | (state_q == ACCESS);

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder on the MEM-stage interface of the pipelined MIPS CPU.
- The EX_MEM register issues MemRead/MemWrite/Addr/WriteData. This block services each access after a configurable latency.
- While an access is in flight it asserts stall_o so the pipeline freezes.
- It completes each access with a one-cycle ack_o, returning read data or an error flag.

Parameters:
- DEPTH, 256: number of 32-bit words in the internal array. Must be a power of 2.
- ADDR_W, 8: log2(DEPTH), the word-index width.
- LATENCY, 3: cycles spent in ACCESS. Legal values 1..15.

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  synchronous, active-low reset
- MemRead_i  in  1  read request from EX_MEM
- MemWrite_i  in  1  write request from EX_MEM
- Addr_i  in  32  byte address (ALU result)
- WriteData_i  in  32  store data
- ReadData_o  out  32  load data to MEM_WB; valid while ack_o=1
- ack_o  out  1  one-cycle completion pulse
- err_o  out  1  error qualifier; valid while ack_o=1
- stall_o  out  1  freeze PC, IF_ID, ID_EX, EX_MEM; hold MEM_WB

Behaviour:
- Reset (rst_i=0 at clock edge):
  - state=IDLE, cnt=0.
  - ReadData_o=0, ack_o=0, err_o=0.
  - Array contents are not cleared.
  - Reset overrides everything. A write still in ACCESS is aborted and never committed.
- Request: req = MemRead_i | MemWrite_i.
- FSM states IDLE, ACCESS, RESP:
  - IDLE & !req: stay in IDLE.
  - IDLE & req & bad: capture request, go to RESP with err_o=1. No array access.
    - bad = Addr_i[1:0]!=0, or Addr_i[31:ADDR_W+2]!=0, or (MemRead_i & MemWrite_i).
  - IDLE & req & !bad:
    - Capture op, word index Addr_i[ADDR_W+1:2] and WriteData_i.
    - cnt <= LATENCY-1; go to ACCESS.
  - ACCESS & cnt!=0: cnt <= cnt-1.
  - ACCESS & cnt==0:
    - Write: commit captured data to array.
    - Read: register array[idx] into ReadData_o.
    - Go to RESP with err_o=0.
  - RESP: ack_o=1 for exactly this cycle; go unconditionally to IDLE. The request still present on this cycle is not re-sampled.
- stall_o (combinational) = (IDLE & req) | ACCESS. It is 0 in RESP, so the pipeline advances on the RESP edge.
- Latency: request first seen in IDLE at cycle t gives ack_o=1 at cycle t+LATENCY+1. stall_o is high from cycle t through t+LATENCY.
- Inputs are sampled only in IDLE. Changes on the inputs during ACCESS are ignored.
- ReadData_o:
  - Holds its value after a read until the next read completes.
  - Writes leave it unchanged.
  - An erroring request drives it to 0.
- err_o is 0 whenever ack_o is 0.
- Back-to-back requests: a new req in the IDLE cycle after RESP starts a new access. Each access is therefore at least LATENCY+2 cycles apart.
- The counter is 4 bits and never wraps: LATENCY is at most 15 and cnt is loaded only from IDLE.

Decomposition:
- Shared package cpu_pkg holds:
  - the state enum {IDLE, ACCESS, RESP};
  - the constants WORD_BYTES=4 and DMEM_LATENCY_DEFAULT=3.
- Sub-module dmem_array:
  - synchronous single-port DEPTH x 32 memory;
  - ports clk_i, we_i, idx_i, wdata_i, rdata_o.
  - The FSM, counter and stall logic stay in dmem_responder.

Test Plan:
- Reset then idle: rst_i=0 for 2 cycles -> ReadData_o=0, ack_o=0, err_o=0, stall_o=0.
- Write then read, LATENCY=3:
  - Write 0xDEADBEEF to Addr 0x10 -> stall_o high for 4 cycles, ack_o at t+4, err_o=0.
  - Then read 0x10 -> ReadData_o=0xDEADBEEF at its ack.
- Misaligned read at Addr 0x13 -> ack_o=1 at t+1, err_o=1, ReadData_o=0, array unchanged; a later read of 0x10 returns 0xDEADBEEF.
- Illegal requests, each -> err_o=1 with ack_o at t+1:
  - Addr 0x400 with DEPTH=256 (out of range);
  - MemRead_i and MemWrite_i both high.
- Reset mid-access: write 0x12345678 to Addr 0x20, drop rst_i during ACCESS cnt=1 -> no ack_o; a subsequent read of 0x20 returns the prior contents.
- Back-to-back, LATENCY=1: read 0x10 immediately followed by write 0x5 to 0x14 -> acks at t+2 and t+5; input changes during ACCESS have no effect.
